// File: rtl/spi_adc_poller_pkg.sv
// Shared types and sizing helpers for the SPI ADC round-robin poller.
package spi_adc_poller_pkg;

  typedef enum logic [2:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RDY,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_adc_poller.sv
// Round-robin SPI ADC poller: one SPIMaster transaction per channel, results
// kept in a per-channel bank with valid flags; free-run or one-shot frames.
module spi_adc_poller
  import spi_adc_poller_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int CMD_BITS   = 8,
  parameter int RES_BITS   = 10,
  parameter int CMD_PREFIX = 'h18,
  parameter int XFER_LEN   = 18,
  parameter int GAP        = 100,
  parameter int TIMEOUT    = 4096,
  parameter int PERIOD     = 50000,
  localparam int CH_W      = $clog2(NCH),
  localparam int LEN_W     = $clog2(CMD_BITS + RES_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                trigger,
  output logic                spi_stb_wr,
  output logic [CMD_BITS-1:0] spi_to_data,
  output logic [LEN_W-1:0]    spi_total_len,
  input  logic                spi_stb_rdy,
  input  logic [RES_BITS-1:0] spi_from_data,
  input  logic [CH_W-1:0]     rd_addr,
  output logic [RES_BITS-1:0] rd_data,
  output logic [NCH-1:0]      valid,
  output logic                busy,
  output logic                frame_stb,
  output logic                err_timeout,
  input  logic                err_clr
);

  localparam int CNT_W = cnt_width(max_int(TIMEOUT, GAP));
  localparam int PER_W = cnt_width(PERIOD);
  localparam int PFX_W = CMD_BITS - CH_W;
  localparam logic [PFX_W-1:0] PFX = PFX_W'(CMD_PREFIX);

  state_t              state_reg;
  logic [CH_W-1:0]     ch_reg;
  logic [CH_W-1:0]     ch_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [PER_W-1:0]    period_reg;
  logic                primed_reg;
  logic                period_expired;
  logic                start_req;
  logic [RES_BITS-1:0] result_mem [NCH];

  assign spi_total_len  = LEN_W'(XFER_LEN);
  assign ch_next        = ch_reg + 1'b1;
  assign period_expired = (period_reg == PER_W'(PERIOD - 1));
  // The first free-run frame after reset goes out as soon as holdoff ends
  // rather than waiting a full period.
  assign start_req      = trigger || (enable && (!primed_reg || period_expired));

  assign rd_data = (32'(rd_addr) < NCH) ? result_mem[rd_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_HOLDOFF;
      ch_reg      <= '0;
      cnt_reg     <= '0;
      period_reg  <= '0;
      primed_reg  <= 1'b0;
      spi_stb_wr  <= 1'b0;
      spi_to_data <= '0;
      valid       <= '0;
      busy        <= 1'b0;
      frame_stb   <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < NCH; i++) result_mem[i] <= '0;
    end else begin
      if (!period_expired) period_reg <= period_reg + 1'b1;
      spi_stb_wr <= 1'b0;
      frame_stb  <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;

      case (state_reg)
        ST_HOLDOFF: begin
          if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (start_req) begin
            ch_reg      <= '0;
            busy        <= 1'b1;
            period_reg  <= '0;
            primed_reg  <= 1'b1;
            spi_stb_wr  <= 1'b1;
            spi_to_data <= {PFX, CH_W'(0)};
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (spi_stb_rdy) begin
            result_mem[ch_reg] <= spi_from_data;
            valid[ch_reg]      <= 1'b1;
            cnt_reg            <= '0;
            state_reg          <= ST_GAP;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            // Stale result is kept; only its valid flag drops.
            err_timeout   <= 1'b1;
            valid[ch_reg] <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_reg == CNT_W'(GAP - 1)) begin
            cnt_reg <= '0;
            if (ch_reg == CH_W'(NCH - 1)) begin
              frame_stb <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              ch_reg      <= ch_next;
              spi_stb_wr  <= 1'b1;
              spi_to_data <= {PFX, ch_next};
              state_reg   <= ST_ISSUE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_HOLDOFF;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_poller.sv
// Directed bench for spi_adc_poller with a behavioural SPIMaster/ADC stub
// answering 10'h200+ch a fixed latency after each stb_wr.
module tb_spi_adc_poller;

  localparam int NCH      = 8;
  localparam int TIMEOUT  = 256;
  localparam int GAP      = 10;
  localparam int PERIOD   = 2000;
  localparam int LAT      = 20;

  logic       clk = 1'b0;
  logic       rst_n, enable, trigger, err_clr;
  logic       spi_stb_wr, spi_stb_rdy, busy, frame_stb, err_timeout;
  logic [7:0] spi_to_data, valid;
  logic [4:0] spi_total_len;
  logic [9:0] spi_from_data, rd_data;
  logic [2:0] rd_addr;

  always #5 clk = ~clk;

  spi_adc_poller #(
    .NCH(NCH), .CMD_BITS(8), .RES_BITS(10), .CMD_PREFIX('h18), .XFER_LEN(18),
    .GAP(GAP), .TIMEOUT(TIMEOUT), .PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
    .spi_stb_wr(spi_stb_wr), .spi_to_data(spi_to_data), .spi_total_len(spi_total_len),
    .spi_stb_rdy(spi_stb_rdy), .spi_from_data(spi_from_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .valid(valid), .busy(busy),
    .frame_stb(frame_stb), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  typedef struct {
    logic [2:0] addr;
    logic [9:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab [8];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, wr_cnt = 0, frame_cnt = 0, last_rdy_cyc = -1, gap5 = -1;
  logic [7:0] cmd5 = '0;
  int f0_q[$];
  bit silent_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (spi_stb_wr) begin
      wr_cnt++;
      if (spi_to_data[2:0] == 3'd0) f0_q.push_back(cyc);
      if (spi_to_data[2:0] == 3'd5) begin
        cmd5 = spi_to_data;
        gap5 = cyc - last_rdy_cyc;
      end
    end
    if (spi_stb_rdy) last_rdy_cyc = cyc;
    if (frame_stb) frame_cnt++;
  end

  // SPIMaster + ADC stub; channel 2 stays silent when silent_en is set.
  initial begin
    logic [7:0] cmd;
    spi_stb_rdy   = 1'b0;
    spi_from_data = '0;
    forever begin
      @(posedge clk); #1;
      if (spi_stb_wr) begin
        cmd = spi_to_data;
        repeat (LAT) @(posedge clk);
        #1;
        if (silent_en && cmd[2:0] == 3'd2) begin
          $display("xfer cmd=%h ch=%0d no response", cmd, cmd[2:0]);
        end else begin
          spi_from_data = 10'h200 + 10'(cmd[2:0]);
          spi_stb_rdy   = 1'b1;
          @(posedge clk); #1;
          spi_stb_rdy   = 1'b0;
          $display("xfer cmd=%h ch=%0d data=%h", cmd, cmd[2:0], spi_from_data);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, int'(frame_cnt >= target), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  // Releases reset and checks that the first stb_wr lands TIMEOUT+1 edges later on ch0.
  task automatic release_and_check_holdoff(input string name);
    int n = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    while (!spi_stb_wr && n < TIMEOUT + 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, TIMEOUT + 1);
    check({name, "_cmd"}, int'(spi_to_data), 'hC0);
  endtask

  initial begin
    int n, sz, fc;
    rst_n = 1'b0; enable = 1'b0; trigger = 1'b0; err_clr = 1'b0; rd_addr = '0;
    rd_tab[0] = '{3'd0, 10'h200}; rd_tab[1] = '{3'd1, 10'h201};
    rd_tab[2] = '{3'd2, 10'h202}; rd_tab[3] = '{3'd3, 10'h203};
    rd_tab[4] = '{3'd4, 10'h204}; rd_tab[5] = '{3'd5, 10'h205};
    rd_tab[6] = '{3'd6, 10'h206}; rd_tab[7] = '{3'd7, 10'h207};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_stb_wr", int'(spi_stb_wr), 0);
    check("rst_to_data", int'(spi_to_data), 0);
    check("rst_frame_stb", int'(frame_stb), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("total_len", int'(spi_total_len), 18);

    // Free-run start after holdoff; enable dropped mid-frame lets the frame finish.
    enable = 1'b1;
    release_and_check_holdoff("holdoff1");
    enable = 1'b0;
    wait_frames(1, 2000, "frame1_wait");
    check("f1_busy", int'(busy), 0);
    check("f1_valid", int'(valid), 'hFF);
    check("f1_frames", frame_cnt, 1);
    check("f1_wr_cnt", wr_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      rd_addr = rd_tab[i].addr;
      #1;
      check($sformatf("rd_ch%0d", i), int'(rd_data), int'(rd_tab[i].exp));
    end
    check("cmd_ch5", int'(cmd5), 'hC5);
    check("gap_ch5", gap5, GAP + 1);
    repeat (PERIOD + 200) @(posedge clk);
    check("no_freerun", frame_cnt, 1);

    // One-shot trigger; a second trigger while busy is ignored.
    pulse_trigger();
    check("trig_busy", int'(busy), 1);
    repeat (50) @(posedge clk);
    pulse_trigger();
    wait_frames(2, 2000, "frame2_wait");
    repeat (400) @(posedge clk);
    check("trig_frames", frame_cnt, 2);
    check("trig_wr_cnt", wr_cnt, 16);

    // Silent channel 2: timeout, valid cleared, stale result kept, frame completes.
    silent_en = 1'b1;
    pulse_trigger();
    wait_frames(3, 3000, "frame3_wait");
    silent_en = 1'b0;
    check("to_err", int'(err_timeout), 1);
    check("to_valid", int'(valid), 'hFB);
    rd_addr = 3'd2; #1;
    check("to_kept", int'(rd_data), 'h202);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("err_clr", int'(err_timeout), 0);

    // Reset during WAIT_RDY of ch4.
    pulse_trigger();
    n = 0;
    while (!(spi_stb_wr && spi_to_data[2:0] == 3'd4) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ch4_seen", int'(n < 1000), 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_to_data", int'(spi_to_data), 0);
    check("arst_rd_data", int'(rd_data), 0);
    enable = 1'b1;
    fc = frame_cnt;
    sz = f0_q.size();
    release_and_check_holdoff("holdoff2");
    check("stray_rdy_ignored", int'(valid), 0);

    // Free-run frame spacing equals PERIOD when frames are shorter.
    n = 0;
    while (f0_q.size() < sz + 2 && n < PERIOD + 500) begin
      @(posedge clk);
      n++;
    end
    check("period_seen", int'(f0_q.size() >= sz + 2), 1);
    if (f0_q.size() >= sz + 2) check("period_spacing", f0_q[sz+1] - f0_q[sz], PERIOD);
    enable = 1'b0;
    wait_frames(fc + 2, 1000, "last_frame_wait");
    check("end_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
